// File: rtl/img_rx_stream_writer_if.sv
// Pixel stream input and SRAM write port bundle for img_rx_stream_writer.
// master = the writer, slave = stream source / SRAM side.
interface img_rx_stream_writer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned COL_W  = 8,
  parameter int unsigned CH_W   = 1
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              sram_sense_en;
  logic              sram_we;
  logic [ROW_W-1:0]  sram_row;
  logic [COL_W-1:0]  sram_col;
  logic [CH_W-1:0]   sram_ch;
  logic [DATA_W-1:0] sram_din;

  modport master (
    input  in_valid, in_data,
    output in_ready, sram_sense_en, sram_we, sram_row, sram_col, sram_ch, sram_din
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, sram_sense_en, sram_we, sram_row, sram_col, sram_ch, sram_din
  );
endinterface

// File: rtl/img_rx_stream_writer.sv
// Writes an interleaved pixel stream into an SRAM window, raster or column-major,
// one channel plane per beat, with zero-latency write strobe.
module img_rx_stream_writer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned COL_W  = 8,
  parameter int unsigned NCH    = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             col_major,
  input  logic [ROW_W:0]   nrows,
  input  logic [COL_W:0]   ncols,
  input  logic [ROW_W-1:0] base_row,
  input  logic [COL_W-1:0] base_col,
  output logic             busy,
  output logic             done,
  output logic             err,
  img_rx_stream_writer_if.master bus
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             col_major_q;
  logic [ROW_W:0]   nrows_q;
  logic [COL_W:0]   ncols_q;
  logic [ROW_W-1:0] base_row_q;
  logic [COL_W-1:0] base_col_q;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             err_q, err_d;
  logic             latch;

  logic [ROW_W+1:0] row_sum;
  logic [COL_W+1:0] col_sum;
  logic             cfg_ok, row_last, col_last, ch_last;

  // Window must be non-empty and fit inside the SRAM address space.
  assign row_sum = (ROW_W+2)'(base_row) + (ROW_W+2)'(nrows);
  assign col_sum = (COL_W+2)'(base_col) + (COL_W+2)'(ncols);
  assign cfg_ok  = (nrows != '0) && (ncols != '0) &&
                   (row_sum <= {2'b01, {ROW_W{1'b0}}}) &&
                   (col_sum <= {2'b01, {COL_W{1'b0}}});

  assign row_last = ({1'b0, row_q} == nrows_q - (ROW_W+1)'(1));
  assign col_last = ({1'b0, col_q} == ncols_q - (COL_W+1)'(1));
  assign ch_last  = (ch_q == CH_W'(NCH - 1));

  assign busy              = (state_q != IDLE);
  assign done              = (state_q == DONE);
  assign err               = err_q;
  assign bus.in_ready      = (state_q == RUN) && !abort;
  assign bus.sram_we       = bus.in_ready && bus.in_valid;
  assign bus.sram_sense_en = 1'b1;
  assign bus.sram_din      = bus.in_data;
  assign bus.sram_row      = base_row_q + row_q;
  assign bus.sram_col      = base_col_q + col_q;
  assign bus.sram_ch       = ch_q;

  // Next state and counter advance: channel innermost, then the traversal-inner axis.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    ch_d    = ch_q;
    err_d   = err_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            latch   = 1'b1;
            err_d   = 1'b0;
            row_d   = '0;
            col_d   = '0;
            ch_d    = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          row_d   = '0;
          col_d   = '0;
          ch_d    = '0;
          state_d = IDLE;
        end else if (bus.in_valid) begin
          if (!ch_last) begin
            ch_d = ch_q + CH_W'(1);
          end else begin
            ch_d = '0;
            if (col_major_q) begin
              if (!row_last) begin
                row_d = row_q + ROW_W'(1);
              end else begin
                row_d = '0;
                col_d = col_last ? '0 : col_q + COL_W'(1);
              end
            end else begin
              if (!col_last) begin
                col_d = col_q + COL_W'(1);
              end else begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
              end
            end
            if (row_last && col_last) state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      col_major_q <= 1'b0;
      nrows_q     <= '0;
      ncols_q     <= '0;
      base_row_q  <= '0;
      base_col_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ch_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      if (latch) begin
        col_major_q <= col_major;
        nrows_q     <= nrows;
        ncols_q     <= ncols;
        base_row_q  <= base_row;
        base_col_q  <= base_col;
      end
    end
  end

endmodule

// File: tb/tb_img_rx_stream_writer.sv
// Randomized bench for img_rx_stream_writer: a queue-based frame model predicts every
// write address and handshake, checked each cycle on the falling edge.
module tb_img_rx_stream_writer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROW_W  = 8;
  localparam int unsigned COL_W  = 8;
  localparam int unsigned NCH    = 3;
  localparam int unsigned CH_W   = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start, abort, col_major;
  logic [ROW_W:0]   nrows;
  logic [COL_W:0]   ncols;
  logic [ROW_W-1:0] base_row;
  logic [COL_W-1:0] base_col;
  logic             busy, done, err;

  img_rx_stream_writer_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .CH_W(CH_W)) bus ();

  img_rx_stream_writer #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .NCH(NCH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .col_major(col_major),
    .nrows(nrows), .ncols(ncols), .base_row(base_row), .base_col(base_col),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: remaining expected writes of the current frame, encoded row<<16|col<<8|ch.
  int exp_q[$];
  bit m_run, m_done, m_err;
  int m_writes;
  int dut_writes, done_seen;
  int seen_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int enc(input int r, input int c, input int ch);
    return (r << 16) | (c << 8) | ch;
  endfunction

  always @(negedge clk) begin
    bit exp_rdy, exp_we, ok;
    int a;
    if (!rstn) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk("rst_we", 32'(bus.sram_we), 0);
      chk("rst_addr", enc(int'(bus.sram_row), int'(bus.sram_col), int'(bus.sram_ch)), 0);
      chk("rst_sense", 32'(bus.sram_sense_en), 1);
      m_run = 0; m_done = 0; m_err = 0; exp_q.delete();
    end else begin
      exp_rdy = m_run && !abort;
      exp_we  = exp_rdy && bus.in_valid;
      chk("busy", 32'(busy), 32'(m_run || m_done));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      chk("sram_we", 32'(bus.sram_we), 32'(exp_we));
      chk("sense_en", 32'(bus.sram_sense_en), 1);
      if (bus.sram_we === 1'b1) begin
        dut_writes++;
        seen_q.push_back(enc(int'(bus.sram_row), int'(bus.sram_col), int'(bus.sram_ch)));
      end
      if (done === 1'b1) done_seen++;
      if (exp_we && exp_q.size() > 0) begin
        chk("addr", enc(int'(bus.sram_row), int'(bus.sram_col), int'(bus.sram_ch)), exp_q[0]);
        chk("din", 32'(bus.sram_din), 32'(bus.in_data));
      end
      // Advance the model to what the next cycle must show.
      if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (abort) begin
          m_run = 0;
          exp_q.delete();
        end else if (exp_we) begin
          a = exp_q.pop_front();
          m_writes++;
          if (exp_q.size() == 0) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end else if (start) begin
        ok = (nrows != 0) && (ncols != 0) &&
             (int'(base_row) + int'(nrows) <= 256) && (int'(base_col) + int'(ncols) <= 256);
        if (ok) begin
          exp_q.delete();
          if (col_major) begin
            for (int c = 0; c < int'(ncols); c++)
              for (int r = 0; r < int'(nrows); r++)
                for (int h = 0; h < int'(NCH); h++)
                  exp_q.push_back(enc(int'(base_row) + r, int'(base_col) + c, h));
          end else begin
            for (int r = 0; r < int'(nrows); r++)
              for (int c = 0; c < int'(ncols); c++)
                for (int h = 0; h < int'(NCH); h++)
                  exp_q.push_back(enc(int'(base_row) + r, int'(base_col) + c, h));
          end
          m_err = 0; m_run = 1; m_writes = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_cfg();
    col_major = 1'($urandom);
    nrows     = 9'($urandom);
    ncols     = 9'($urandom);
    base_row  = 8'($urandom);
    base_col  = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start         = 1'b0;
      abort         = 1'($urandom);
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 8'($urandom);
      tick();
    end
    abort = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input int nr, input int nc, input int br, input int bc, input bit cm,
                           input int vpct, input int abort_after, input bit junk);
    bit fin;
    dut_writes = 0; done_seen = 0; seen_q.delete();
    nrows = 9'(nr); ncols = 9'(nc); base_row = 8'(br); base_col = 8'(bc); col_major = cm;
    start = 1'b1; abort = 1'b0; bus.in_valid = 1'b0;
    tick();
    start = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (!m_run && !m_done) begin
        fin = 1'b1;
        break;
      end
      bus.in_valid = ($urandom_range(99) < vpct);
      bus.in_data  = 8'($urandom);
      abort = (abort_after >= 0 && m_run && m_writes == abort_after && bus.in_valid) ||
              (m_done && $urandom_range(1) == 0);
      start = ($urandom_range(7) == 0);
      if (junk) junk_cfg();
      tick();
    end
    if (!fin) chk("frame_timeout", 1, 0);
    start = 1'b0; abort = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; col_major = 1'b0;
    nrows = '0; ncols = '0; base_row = '0; base_col = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) tick();
    rstn = 1'b1;
    idle_cycles(4);

    // 2x3 raster, continuous input.
    run_frame(2, 3, 0, 0, 0, 100, -1, 1);
    chk("r25_writes", dut_writes, 18);
    chk("r25_done", done_seen, 1);
    chk("r25_w3", seen_q[3], enc(0, 1, 0));
    chk("r25_w9", seen_q[9], enc(1, 0, 0));
    chk("r25_w17", seen_q[17], enc(1, 2, 2));

    // Offset window, channel interleave.
    run_frame(1, 2, 5, 10, 0, 100, -1, 1);
    chk("r26_writes", dut_writes, 6);
    chk("r26_w0", seen_q[0], enc(5, 10, 0));
    chk("r26_w2", seen_q[2], enc(5, 10, 2));
    chk("r26_w3", seen_q[3], enc(5, 11, 0));

    // Column-major with gaps.
    run_frame(2, 2, 0, 0, 1, 40, -1, 1);
    chk("r27_writes", dut_writes, 12);
    chk("r27_w3", seen_q[3], enc(1, 0, 0));
    chk("r27_w6", seen_q[6], enc(0, 1, 0));

    // Row window overflows the array.
    run_frame(10, 2, 250, 0, 0, 100, -1, 0);
    chk("r28_err", 32'(err), 1);
    chk("r28_busy", 32'(busy), 0);
    chk("r28_writes", dut_writes, 0);
    run_frame(0, 2, 0, 0, 0, 100, -1, 0);
    chk("zero_rows_err", 32'(err), 1);
    run_frame(1, 6, 3, 250, 0, 100, -1, 0);
    chk("edge_col_err", 32'(err), 0);
    chk("edge_col_writes", dut_writes, 18);
    run_frame(1, 7, 3, 250, 0, 100, -1, 0);
    chk("over_col_err", 32'(err), 1);

    // Abort on the 4th beat.
    run_frame(2, 3, 0, 0, 0, 100, 3, 1);
    chk("r29_writes", dut_writes, 3);
    chk("r29_done", done_seen, 0);
    chk("r29_busy", 32'(busy), 0);
    run_frame(2, 3, 0, 0, 0, 100, -1, 1);
    chk("r29_restart", seen_q[0], enc(0, 0, 0));

    // Full-height column.
    run_frame(256, 1, 0, 7, 1, 100, -1, 1);
    chk("tall_writes", dut_writes, 768);

    // Reset mid-frame.
    nrows = 9'd3; ncols = 9'd4; base_row = 8'd7; base_col = 8'd9; col_major = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      tick();
    end
    rstn = 1'b0;
    #1;
    chk("r30_busy", 32'(busy), 0);
    chk("r30_we", 32'(bus.sram_we), 0);
    chk("r30_row", 32'(bus.sram_row), 0);
    chk("r30_col", 32'(bus.sram_col), 0);
    tick();
    rstn = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    run_frame(1, 1, 0, 0, 0, 100, -1, 0);
    chk("r30_restart", seen_q[0], enc(0, 0, 0));

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      int br, bc, ab;
      br = ($urandom_range(3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 200);
      bc = ($urandom_range(3) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 200);
      ab = ($urandom_range(4) == 0) ? $urandom_range(0, 20) : -1;
      run_frame($urandom_range(0, 6), $urandom_range(0, 6), br, bc, 1'($urandom),
                $urandom_range(30, 100), ab, 1);
      idle_cycles($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/img_rx_stream_writer.md
IMG_RX_STREAM_WRITER -- requirements
Module: img_rx_stream_writer

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, pixel-channel data width.
REQ-002 SHALL provide parameter ROW_W, default 8, SRAM row address width.
REQ-003 SHALL provide parameter COL_W, default 8, SRAM column address width.
REQ-004 SHALL provide parameter NCH, default 1, channels per pixel (1..4), interleaved on input; CH_W = max(1, clog2(NCH)).
REQ-005 SHALL have ports:
  clk  in  1  clock, rising edge.
  rstn  in  1  asynchronous active-low reset.
  start  in  1  launch a frame transfer, sampled in IDLE only.
  abort  in  1  cancel the transfer in progress.
  col_major  in  1  traversal mode, latched at start: 0 = raster (col inner), 1 = column-major (row inner).
  nrows  in  ROW_W+1  frame rows, latched at start.
  ncols  in  COL_W+1  frame columns, latched at start.
  base_row  in  ROW_W  row offset, latched at start.
  base_col  in  COL_W  column offset, latched at start.
  in_valid  in  1  input beat valid.
  in_data  in  DATA_W  input beat data.
  in_ready  out  1  writer accepts a beat.
  busy  out  1  transfer active (state != IDLE).
  done  out  1  one-cycle frame-complete pulse.
  err  out  1  sticky config error.
  sram_sense_en  out  1  SRAM sense enable, constant 1.
  sram_we  out  1  SRAM write strobe.
  sram_row  out  ROW_W  write row address.
  sram_col  out  COL_W  write column address.
  sram_ch  out  CH_W  write channel plane.
  sram_din  out  DATA_W  write data.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, DONE.
REQ-007 IDLE: start=1 with valid config SHALL latch config, clear counters, clear err, enter RUN next cycle.
REQ-008 Config SHALL be invalid when nrows=0, ncols=0, base_row+nrows > 2^ROW_W, or base_col+ncols > 2^COL_W (sums computed one bit wider than the operands).
REQ-009 start with invalid config SHALL set err=1, stay in IDLE, and produce no write and no done.
REQ-010 in_ready SHALL be 1 only in RUN.
REQ-011 A beat SHALL be accepted when in_valid && in_ready; sram_we SHALL equal in_valid && in_ready in the same cycle (zero latency).
REQ-012 sram_din SHALL equal in_data; sram_row = base_row + row_cnt; sram_col = base_col + col_cnt; sram_ch = ch_cnt; all are combinational from registered counters.
REQ-013 Counters SHALL advance only on an accepted beat: ch_cnt innermost, wrapping at NCH-1; then col_cnt (raster) or row_cnt (column-major); then the other.
REQ-014 in_valid=0 in RUN SHALL hold all counters; stalls of any length are permitted.
REQ-015 Acceptance of the beat with row_cnt=nrows-1, col_cnt=ncols-1, and ch_cnt=NCH-1 SHALL move the FSM to DONE next cycle.
REQ-016 Exactly nrows*ncols*NCH writes SHALL occur per frame, with no duplicate addresses.
REQ-017 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-018 start in RUN or DONE SHALL be ignored.
REQ-019 abort in RUN SHALL suppress sram_we and in_ready that cycle, clear counters, and return to IDLE next cycle without done; abort has priority over a final beat.
REQ-020 abort in IDLE or DONE SHALL have no effect.
REQ-021 Latched config SHALL remain stable for the whole frame regardless of input changes.

Reset
REQ-022 rstn=0 SHALL asynchronously force IDLE, clear all counters and latched config, and drive busy=0, done=0, err=0, in_ready=0, sram_we=0.
REQ-023 After reset, sram_row, sram_col, sram_ch = 0 and sram_sense_en = 1; release SHALL be synchronous to clk.
REQ-024 Reset mid-frame SHALL discard the frame; the next start begins at index 0.

Verification
REQ-025 NCH=1, nrows=2, ncols=3, base 0/0, raster, in_valid always 1 -> 6 writes at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); done one cycle after the 6th write.
REQ-026 NCH=3, nrows=1, ncols=2, base_row=5, base_col=10 -> 6 writes at (5,10,ch0..2),(5,11,ch0..2); data order preserved.
REQ-027 col_major=1, nrows=2, ncols=2, random in_valid gaps -> writes at (0,0),(1,0),(0,1),(1,1); no write while in_valid=0.
REQ-028 ROW_W=8, base_row=250, nrows=10 -> err=1, busy stays 0, no sram_we; a later valid start clears err.
REQ-029 abort asserted on the 4th beat of a 2x3 frame -> 3 writes only, no done, IDLE next cycle; the following start restarts at (0,0).
REQ-030 rstn pulsed low mid-frame -> all outputs at reset values immediately; start ignored while busy is checked separately.
